// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: start/stop MM:SS BCD stopwatch advanced by rising edges of the 1 Hz div_clock.
// Defining STOPWATCH_BCD_LAP_EN adds a lap-hold toggle that freezes the digit outputs.
module stopwatch_bcd #(
    parameter int MIN_WRAP = 59
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       div_clock,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       sec_tick,
    output logic       wrap
);
    localparam logic [3:0] WRAP_TENS = 4'(MIN_WRAP / 10);
    localparam logic [3:0] WRAP_ONES = 4'(MIN_WRAP % 10);

    typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_e;

    state_e     state_q, state_d;
    logic       div_q, div_d;
    logic [3:0] so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
    logic       running_q, running_d, tick_q, tick_d, wrap_q, wrap_d;
    logic       edge_s, advance_s, at_wrap_s;

    // Edge detect, start/stop toggle and the BCD carry chain
    always_comb begin
        div_d     = div_clock;
        state_d   = state_q;
        so_d      = so_q;
        st_d      = st_q;
        mo_d      = mo_q;
        mt_d      = mt_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        edge_s    = div_clock & ~div_q;
        // Advance uses the pre-toggle state, so a stopping pulse still counts its edge
        advance_s = edge_s & (state_q == ST_RUNNING) & ~clear;
        at_wrap_s = (mt_q == WRAP_TENS) && (mo_q == WRAP_ONES) &&
                    (st_q == 4'd5) && (so_q == 4'd9);

        if (start_stop) begin
            state_d = (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
        end else begin
            state_d = state_q;
        end
        running_d = (state_d == ST_RUNNING);

        if (clear) begin
            so_d = 4'd0;
            st_d = 4'd0;
            mo_d = 4'd0;
            mt_d = 4'd0;
        end else if (advance_s) begin
            tick_d = 1'b1;
            if (at_wrap_s) begin
                so_d   = 4'd0;
                st_d   = 4'd0;
                mo_d   = 4'd0;
                mt_d   = 4'd0;
                wrap_d = 1'b1;
            end else if (so_q != 4'd9) begin
                so_d = so_q + 4'd1;
            end else begin
                so_d = 4'd0;
                if (st_q != 4'd5) begin
                    st_d = st_q + 4'd1;
                end else begin
                    st_d = 4'd0;
                    if (mo_q != 4'd9) begin
                        mo_d = mo_q + 4'd1;
                    end else begin
                        mo_d = 4'd0;
                        mt_d = (mt_q == 4'd9) ? 4'd0 : mt_q + 4'd1;
                    end
                end
            end
        end else begin
            so_d = so_q;
        end
    end

    // Count, FSM and pulse registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_q     <= 1'b1;
            state_q   <= ST_STOPPED;
            so_q      <= 4'd0;
            st_q      <= 4'd0;
            mo_q      <= 4'd0;
            mt_q      <= 4'd0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            so_q      <= so_d;
            st_q      <= st_d;
            mo_q      <= mo_d;
            mt_q      <= mt_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign running  = running_q;
    assign sec_tick = tick_q;
    assign wrap     = wrap_q;

`ifdef STOPWATCH_BCD_LAP_EN
    logic        lap_hold_q, lap_hold_d;
    logic [15:0] disp_q, disp_d;

    // Lap-hold toggle; the snapshot is the value on display when the hold engages
    always_comb begin
        lap_hold_d = lap_hold_q;
        disp_d     = disp_q;
        if (clear) begin
            lap_hold_d = 1'b0;
        end else if (lap) begin
            lap_hold_d = ~lap_hold_q;
        end else begin
            lap_hold_d = lap_hold_q;
        end
        if (!lap_hold_d) begin
            disp_d = {mt_d, mo_d, st_d, so_d};
        end else if (!lap_hold_q) begin
            disp_d = {mt_q, mo_q, st_q, so_q};
        end else begin
            disp_d = disp_q;
        end
    end

    // Display registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lap_hold_q <= 1'b0;
            disp_q     <= 16'd0;
        end else begin
            lap_hold_q <= lap_hold_d;
            disp_q     <= disp_d;
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = disp_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign {min_tens, min_ones, sec_tens, sec_ones} = {mt_q, mo_q, st_q, so_q};
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: vector table, directed corner sequences and random stimulus
// checked against a seconds-count reference model (two instances, MIN_WRAP 59 and 2).
module tb_stopwatch_bcd;
    logic clock = 1'b0;
    always #50 clock = ~clock;

    logic reset_n, div_clock, start_stop, clear, lap;
    logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
    logic a_run, a_tick, a_wrap, b_run, b_tick, b_wrap;

    stopwatch_bcd #(.MIN_WRAP(59)) dut_a (
        .clock(clock), .reset_n(reset_n), .div_clock(div_clock), .start_stop(start_stop),
        .clear(clear), .lap(lap), .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo),
        .min_tens(a_mt), .running(a_run), .sec_tick(a_tick), .wrap(a_wrap));

    stopwatch_bcd #(.MIN_WRAP(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .div_clock(div_clock), .start_stop(start_stop),
        .clear(clear), .lap(lap), .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo),
        .min_tens(b_mt), .running(b_run), .sec_tick(b_tick), .wrap(b_wrap));

    int n_checks = 0;
    int n_fail = 0;
    int ticks_seen = 0;

    // Reference model: elapsed seconds as a plain integer per instance
    int wrap_min [2] = '{59, 2};
    int m_secs [2];
    int m_snap [2];
    int m_disp [2];
    bit m_tick [2];
    bit m_wrap [2];
    bit m_run, m_prev, m_hold;

    function automatic logic [18:0] expect_of(int secs, bit run, bit tick, bit wrp);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run, tick, wrp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit edge_v, new_hold;
        if (!reset_n) begin
            m_run = 1'b0; m_prev = 1'b1; m_hold = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_secs[k] = 0; m_disp[k] = 0; m_tick[k] = 1'b0; m_wrap[k] = 1'b0;
            end
        end else begin
            edge_v = div_clock && !m_prev;
            m_prev = div_clock;
`ifdef STOPWATCH_BCD_LAP_EN
            new_hold = clear ? 1'b0 : (lap ? !m_hold : m_hold);
`else
            new_hold = 1'b0;
`endif
            for (int k = 0; k < 2; k++) begin
                if (new_hold && !m_hold) m_snap[k] = m_secs[k];
                m_tick[k] = 1'b0;
                m_wrap[k] = 1'b0;
                if (clear) begin
                    m_secs[k] = 0;
                end else if (edge_v && m_run) begin
                    m_tick[k] = 1'b1;
                    if (m_secs[k] == wrap_min[k] * 60 + 59) begin
                        m_secs[k] = 0;
                        m_wrap[k] = 1'b1;
                    end else begin
                        m_secs[k] = m_secs[k] + 1;
                    end
                end
                m_disp[k] = new_hold ? m_snap[k] : m_secs[k];
            end
            m_hold = new_hold;
            if (start_stop) m_run = !m_run;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check("model_a", {a_mt, a_mo, a_st, a_so, a_run, a_tick, a_wrap},
              expect_of(m_disp[0], m_run, m_tick[0], m_wrap[0]));
        check("model_b", {b_mt, b_mo, b_st, b_so, b_run, b_tick, b_wrap},
              expect_of(m_disp[1], m_run, m_tick[1], m_wrap[1]));
        if (a_tick) ticks_seen++;
    endtask

    task automatic do_edge();
        div_clock = 1'b0;
        cycle();
        div_clock = 1'b1;
        cycle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; div_clock = 1'b1;
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cycle();
        start_stop = 1'b0;
    endtask

    typedef struct {
        logic rst, div, ss, clr, lp;
        logic [15:0] dig;
        logic run, tick, wrp;
    } vec_t;
    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0; div_clock = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;

        for (int i = 0; i < 14; i++) begin
            reset_n = vecs[i].rst; div_clock = vecs[i].div; start_stop = vecs[i].ss;
            clear = vecs[i].clr; lap = vecs[i].lp;
            cycle();
            check($sformatf("vec%0d", i), {a_mt, a_mo, a_st, a_so, a_run, a_tick, a_wrap},
                  {vecs[i].dig, vecs[i].run, vecs[i].tick, vecs[i].wrp});
        end

        // Count 12, then carry into minutes, then full wrap at 59:59
        do_reset();
        pulse_ss();
        ticks_seen = 0;
        repeat (12) do_edge();
        check("count_12", {a_mt, a_mo, a_st, a_so}, 16'h0012);
        check("ticks_12", ticks_seen, 12);
        repeat (47) do_edge();
        check("count_59", {a_mt, a_mo, a_st, a_so}, 16'h0059);
        do_edge();
        check("carry_min", {a_mt, a_mo, a_st, a_so}, 16'h0100);
        repeat (3539) do_edge();
        check("at_5959", {a_mt, a_mo, a_st, a_so, a_wrap}, {16'h5959, 1'b0});
        do_edge();
        check("wrap_a", {a_mt, a_mo, a_st, a_so, a_wrap, a_tick}, {16'h0000, 1'b1, 1'b1});
        div_clock = 1'b0;
        cycle();
        check("wrap_a_one", {a_mt, a_mo, a_st, a_so, a_wrap}, {16'h0000, 1'b0});

        // MIN_WRAP = 2 instance
        do_reset();
        pulse_ss();
        repeat (179) do_edge();
        check("b_0259", {b_mt, b_mo, b_st, b_so, b_wrap}, {16'h0259, 1'b0});
        do_edge();
        check("b_wrap", {b_mt, b_mo, b_st, b_so, b_wrap}, {16'h0000, 1'b1});

        // Clear coincident with an edge, then edges while stopped
        do_reset();
        pulse_ss();
        repeat (7) do_edge();
        check("count_7", {a_mt, a_mo, a_st, a_so}, 16'h0007);
        div_clock = 1'b0;
        cycle();
        div_clock = 1'b1; clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("clear_edge", {a_mt, a_mo, a_st, a_so, a_run, a_tick, a_wrap},
              {16'h0000, 1'b1, 1'b0, 1'b0});
        pulse_ss();
        repeat (5) do_edge();
        check("stopped_5", {a_mt, a_mo, a_st, a_so, a_run}, {16'h0000, 1'b0});

`ifdef STOPWATCH_BCD_LAP_EN
        do_reset();
        pulse_ss();
        repeat (3) do_edge();
        div_clock = 1'b0; lap = 1'b1;
        cycle();
        lap = 1'b0;
        repeat (4) do_edge();
        check("lap_hold", {a_mt, a_mo, a_st, a_so, a_tick}, {16'h0003, 1'b1});
        div_clock = 1'b0; lap = 1'b1;
        cycle();
        lap = 1'b0;
        check("lap_release", {a_mt, a_mo, a_st, a_so}, 16'h0007);
`endif

        // Reset mid-count
        do_reset();
        pulse_ss();
        repeat (30) do_edge();
        check("count_30", {a_mt, a_mo, a_st, a_so}, 16'h0030);
        div_clock = 1'b0;
        cycle();
        reset_n = 1'b0; div_clock = 1'b1;
        cycle();
        reset_n = 1'b1;
        check("mid_reset", {a_mt, a_mo, a_st, a_so, a_run, a_tick}, {16'h0000, 1'b0, 1'b0});
        do_edge();
        check("after_reset", {a_mt, a_mo, a_st, a_so, a_run}, {16'h0000, 1'b0});

        // Random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) == 0) div_clock = ~div_clock;
            start_stop = ($urandom_range(0, 24) == 0);
            clear      = ($urandom_range(0, 59) == 0);
            lap        = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Downstream consumer of the 1 Hz divider output (div_clock) in the Lab2 timing chain.
- Detects div_clock rising edges in the 10 MHz domain and runs a start/stop-controlled MM:SS counter.
- Counter is BCD, with four digit outputs that feed the seven-segment display decoders.

Parameters:
- MIN_WRAP, 59, last minutes value before wrapping to 00. Legal range 1..99 decimal; held internally as two BCD digits.

Ports:
- clock  in  1  10 MHz system clock.
- reset_n  in  1  Synchronous active-low reset, sampled on the rising edge of clock.
- div_clock  in  1  1 Hz square wave from the divider, synchronous to clock.
- start_stop  in  1  One-cycle pulse; toggles STOPPED/RUNNING.
- clear  in  1  Level; zeros the count.
- lap  in  1  One-cycle pulse; lap-hold toggle. Ignored unless LAP_EN is defined.
- sec_ones  out  4  Seconds ones digit, BCD 0..9.
- sec_tens  out  4  Seconds tens digit, BCD 0..5.
- min_ones  out  4  Minutes ones digit, BCD 0..9.
- min_tens  out  4  Minutes tens digit, BCD 0..9.
- running  out  1  High in the RUNNING state.
- sec_tick  out  1  One-cycle pulse on each counted second.
- wrap  out  1  One-cycle pulse when MM:SS goes from MIN_WRAP:59 to 00:00.

Behaviour:
- Reset (reset_n low at a clock edge):
  - all digits 0, running 0, sec_tick 0, wrap 0;
  - state STOPPED;
  - edge register div_q set to 1, so a div_clock already high at reset release gives no spurious tick.
- Edge detect:
  - div_q <= div_clock every cycle;
  - edge = div_clock & ~div_q, asserted exactly one cycle per div_clock rising edge.
- FSM states:
  - STOPPED: start_stop -> RUNNING.
  - RUNNING: start_stop -> STOPPED.
  - running = (state == RUNNING), registered.
- Count advance = edge & RUNNING & ~clear, evaluated on the same cycle.
  - Digits, sec_tick and wrap all update on that clock edge, so outputs change 1 cycle after div_clock is first sampled high.
  - sec_tick = 1 for that single cycle; it stays 0 for edges while STOPPED.
- BCD increment chain:
  - sec_ones 9 -> 0, carry into sec_tens;
  - sec_tens 5 with carry -> 0, carry into minutes;
  - min_ones 9 -> 0, carry into min_tens;
  - when minutes == MIN_WRAP and seconds == 59, the next advance gives 00:00 and wrap = 1 for that cycle.
  - No digit ever holds a non-BCD value.
- Priority, highest first: reset_n > clear > advance.
  - clear zeros all digits in either state and leaves the FSM state unchanged.
  - sec_tick and wrap are 0 during any cycle with clear high.
- start_stop and edge in the same cycle: the advance decision uses the state before the toggle. A RUNNING->STOPPED toggle still counts that edge; a STOPPED->RUNNING toggle does not.
- Edges while STOPPED are discarded, not queued.
- Reset mid-count: takes effect on the next clock edge regardless of state or pending edge.

Optional Feature:
- Macro: STOPWATCH_BCD_LAP_EN.
- Defined:
  - Internal lap_hold flag, reset 0, toggled by a lap pulse.
  - While lap_hold = 1, the four digit outputs show a snapshot taken on the cycle lap_hold set, and the internal count keeps advancing.
  - Clearing lap_hold returns the outputs to live values on the next cycle.
  - clear also forces lap_hold = 0.
  - sec_tick, wrap and running are never frozen.
- Undefined: lap is ignored and the digit outputs always show the live count.

Test Plan:
- Reset, then div_clock held high -> no sec_tick; digits 00:00; running 0.
- Pulse start_stop, then 12 div_clock rising edges -> 00:12; exactly 12 sec_tick pulses; each lands 1 cycle after its edge.
- Preload to 00:59 by counting, then 1 edge -> 01:00. From 59:59 (MIN_WRAP = 59), 1 edge -> 00:00 with wrap = 1 for 1 cycle.
- MIN_WRAP = 2, 180 edges -> 00:00 with wrap = 1 on edge 180; 02:59 shown after edge 179.
- At 00:07 RUNNING: clear together with an edge -> 00:00, no sec_tick, running stays 1. Then stop, apply 5 edges -> still 00:00. start_stop coincident with an edge while RUNNING -> count advances once, then STOPPED.
- LAP_EN defined: at 00:03 pulse lap, apply 4 edges -> outputs hold 00:03. Pulse lap again -> 00:07 on the next cycle. Reset mid-count at 00:30 -> 00:00 next edge, STOPPED.
